// File: rtl/sub_unit_param.sv
// sub_unit_param: clocked, parametrised subtractor with a peer ack handshake.
// Captures a/b/mode on start, waits for all peers to grant (bounded by
// ACK_TIMEOUT), then registers the result in one of four subtraction modes.
// While idle it echoes peer_working back as ack_to_peer.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         operation request, honoured only in IDLE
//   a, b, mode    operands and subtraction mode, captured on accepted start
//   ack_in        per-peer grant, all bits must be high to proceed
//   peer_working  per-peer busy flags, acknowledged while idle
//   ack_to_peer   registered grant back to each peer
//   working       high while in REQ or EXEC
//   done          one-cycle completion pulse
//   timeout_err   qualifies done: 1 when the ack wait was aborted
//   result        last successful result
//   borrow        unsigned a<b of the last successful op
//   overflow      saturation/clamp of the last successful op
module sub_unit_param #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned N_PEERS     = 3,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         mode,
    input  logic [N_PEERS-1:0] ack_in,
    input  logic [N_PEERS-1:0] peer_working,
    output logic [N_PEERS-1:0] ack_to_peer,
    output logic               working,
    output logic               done,
    output logic               timeout_err,
    output logic [WIDTH-1:0]   result,
    output logic               borrow,
    output logic               overflow
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       mode_q;

    logic             all_ack;
    logic             limit_hit;
    logic             abort_c;
    logic [WIDTH:0]   diff_c;
    logic             lt_c;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;

    assign all_ack   = &ack_in;
    assign limit_hit = (wait_cnt == CNT_W'(ACK_TIMEOUT));
    // Acks arriving on the limit cycle take priority over the abort.
    assign abort_c   = (state == S_REQ) && !all_ack && limit_hit;

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: if (start) next_state = S_REQ;
            S_REQ: begin
                if (all_ack)        next_state = S_EXEC;
                else if (limit_hit) next_state = S_DONE;
            end
            S_EXEC: next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Subtraction datapath on the captured operands; diff_c MSB is the borrow.
    always_comb begin
        diff_c = {1'b0, a_q} - {1'b0, b_q};
        lt_c   = diff_c[WIDTH];
        res_c  = diff_c[WIDTH-1:0];
        ovf_c  = 1'b0;
        unique case (mode_q)
            2'b00: ;
            2'b01: begin
                if (lt_c) begin
                    res_c = '0;
                    ovf_c = 1'b1;
                end
            end
            2'b10: begin
                // Signed overflow only when operand signs differ and the
                // difference flips away from a's sign.
                if ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_c[WIDTH-1] != a_q[WIDTH-1])) begin
                    ovf_c = 1'b1;
                    res_c = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
            2'b11: begin
                if (lt_c) res_c = b_q - a_q;
            end
            default: ;
        endcase
    end

    // State, counter, operand capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= '0;
            ack_to_peer <= '0;
            working     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            result      <= '0;
            borrow      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= next_state;
            working     <= (next_state == S_REQ) || (next_state == S_EXEC);
            done        <= (next_state == S_DONE);
            timeout_err <= abort_c;
            // Idle echo of peer busy flags; a start in the same cycle wins.
            ack_to_peer <= ((state == S_IDLE) && !start) ? peer_working : '0;

            unique case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= mode;
                    end
                end
                S_REQ: wait_cnt <= wait_cnt + CNT_W'(1);
                S_EXEC: begin
                    result   <= res_c;
                    borrow   <= lt_c;
                    overflow <= ovf_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sub_unit_param.md
# sub_unit_param

Parametrised, clocked successor of the combinational subtractor peer in the arithmetic-unit cluster. Captures two WIDTH-bit operands on `start`, runs an ack handshake with N_PEERS peer units (add/mul/div and future units) before computing, then registers the result in one of four subtraction modes. When idle it acknowledges peers that report themselves working. A bounded ack wait reports a timeout instead of hanging.

## Interface
- WIDTH, 64, operand/result width (≥2)
- N_PEERS, 3, number of peer units in the handshake (≥1)
- ACK_TIMEOUT, 15, max cycles spent in REQ before abort (1..255)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  operation request, sampled only in IDLE
- a, b  in  WIDTH  operands, captured when `start` is accepted
- mode  in  2  captured with operands: 00 wrap, 01 unsigned saturate, 10 signed saturate, 11 absolute difference
- ack_in  in  N_PEERS  per-peer grant, bit i from peer i
- peer_working  in  N_PEERS  per-peer busy indication
- ack_to_peer  out  N_PEERS  registered grant to each peer
- working  out  1  high in REQ and EXEC
- done  out  1  one-cycle pulse on completion (success or timeout)
- timeout_err  out  1  valid with `done`; 1 = aborted
- result  out  WIDTH  registered result, held until next successful completion
- borrow  out  1  unsigned a<b for the last completed op
- overflow  out  1  saturation/clamp occurred for the last completed op

## Operation
- FSM states: IDLE, REQ, EXEC, DONE.
- IDLE: `start`=1 → capture a, b, mode; go to REQ. Otherwise stay; next-cycle `ack_to_peer[i]` = `peer_working[i]`.
- `start` and any `peer_working` in the same IDLE cycle: `start` wins; `ack_to_peer` is driven to all zeros.
- REQ: `ack_to_peer`=0. Wait counter increments each cycle. If all bits of `ack_in` are 1 (AND-reduce), go to EXEC. Otherwise, when the counter reaches ACK_TIMEOUT, go to DONE with the abort flag set. If all acks arrive in the same cycle the limit is reached, the acks win.
- EXEC: compute and register result/borrow/overflow; go to DONE.
- DONE: `done`=1, `timeout_err` = abort flag; go to IDLE. On abort, result/borrow/overflow are unchanged.
- `start` outside IDLE is ignored. It is not queued.
- Arithmetic on captured operands, with d = a−b computed at WIDTH+1 bits; borrow = (a<b unsigned) in all modes:
  - 00: result = d mod 2^WIDTH; overflow=0.
  - 01: if a<b, result=0 and overflow=1; else result=a−b.
  - 10: signed overflow when sign(a)≠sign(b) and sign(a−b)≠sign(a); then clamp to 2^(WIDTH−1)−1 if a is non-negative, else −2^(WIDTH−1); overflow=1.
  - 11: result = a≥b ? a−b : b−a (unsigned); overflow=0.

## Timing
- Reset: state IDLE, wait counter 0, abort flag 0. All outputs 0: ack_to_peer, working, done, timeout_err, result, borrow, overflow.
- `rst` asserted in any state aborts the operation. No `done` is emitted and outputs return to reset values on the next edge.
- Best-case latency: `start` sampled at edge 0 → REQ at cycle 1. With all acks at cycle 1 → EXEC at cycle 2. `done`=1 and result valid at cycle 3.
- Each extra cycle of missing acks adds one cycle of latency.
- Timeout: `done` with `timeout_err`=1 arrives ACK_TIMEOUT+1 cycles after the REQ entry cycle.
- Back-to-back operation: a new `start` is accepted in the IDLE cycle immediately after DONE. Minimum period is 4 cycles.
- `ack_to_peer` changes one cycle after `peer_working` (registered). It is 0 during REQ, EXEC and DONE.

## Test plan
- Wrap, WIDTH=8: a=0x05, b=0x07, mode 00, acks already high → `done` at cycle 3; result=0xFE, borrow=1, overflow=0.
- Saturate, WIDTH=8: mode 01 with a=0x03, b=0x09 → result 0x00, overflow=1. Mode 10 with a=0x80, b=0x01 → result 0x80 (clamped), overflow=1. Mode 10 with a=0x7F, b=0xFF → result 0x7F, overflow=1.
- Abs diff, WIDTH=8: a=0x10, b=0x30, mode 11 → result 0x20, borrow=1.
- Delayed ack, N_PEERS=3: raise ack_in bits at REQ cycles 2, 4, 5 → EXEC entered only after all three are 1; done at cycle 7; `working` high throughout REQ/EXEC; ack_to_peer=000 throughout.
- Timeout, ACK_TIMEOUT=4: ack_in stuck at 3'b011 → `done`=1 with `timeout_err`=1; prior result retained. A following `start` with full acks completes normally.
- Idle ack and reset: in IDLE, peer_working=3'b101 → ack_to_peer=3'b101 next cycle. Same cycle with `start`=1 → ack_to_peer=000. `rst` during REQ → no `done`; all outputs 0 next cycle.
